led_array_ctrl: RTL and testbench
=================================

LED_ARRAY_CTRL -- requirements
Module: led_array_ctrl

Interface
REQ-001 Parameter NCH, default 4: number of LED channels, 1..32.
REQ-002 Parameter CH_W, default 2: cfg_ch width; 2**CH_W >= NCH SHALL hold.
REQ-003 Parameter CNT_W, default 8: per-channel period, duty and counter width.
REQ-004 Parameter PRESCALE, default 1000: sys_clock cycles per tick, >= 2.
REQ-005 sys_clock  in  1  sole clock; all state SHALL update on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 stop  in  1  freeze request; high = prescaler, counters and LEDs hold.
REQ-008 cfg_we  in  1  one-cycle configuration write strobe.
REQ-009 cfg_ch  in  CH_W  target channel of the write.
REQ-010 cfg_mode  in  2  mode: 0 OFF, 1 ON, 2 BLINK, 3 PWM.
REQ-011 cfg_period  in  CNT_W  period value P.
REQ-012 cfg_duty  in  CNT_W  PWM duty value D.
REQ-013 led  out  NCH  registered LED drive, bit i = channel i, 1 = lit.
REQ-014 tick  out  1  registered one-cycle prescaler pulse.

Function
REQ-015 The prescaler SHALL count 0..PRESCALE-1 and wrap to 0; tick SHALL be high for the cycle after the count reaches PRESCALE-1.
REQ-016 With stop high, the prescaler, all channel counters, phases and led SHALL hold, and tick SHALL be 0.
REQ-017 Each channel SHALL hold the registers mode, period, duty, cnt (CNT_W) and phase (1 bit).
REQ-018 If cfg_we=1 and cfg_ch<NCH, the channel SHALL load mode/period/duty and clear cnt and phase; the write SHALL be accepted regardless of stop.
REQ-019 If cfg_we=1 and cfg_ch>=NCH, the write SHALL be ignored with no state change.
REQ-020 On a write to a channel in the same cycle as a tick, the write SHALL take priority; no count occurs that cycle.
REQ-021 OFF: led[i]=0; cnt and phase SHALL hold.
REQ-022 ON: led[i]=1; cnt and phase SHALL hold.
REQ-023 BLINK, per tick: if cnt==period then cnt<=0 and phase toggles, else cnt<=cnt+1; led[i]=phase.
REQ-024 BLINK period P SHALL give a half-period of P+1 ticks; P=0 SHALL toggle every tick.
REQ-025 PWM, per tick: cnt<=(cnt>=period)?0:cnt+1, giving a PWM period of P+1 ticks.
REQ-026 PWM led[i] SHALL be (cnt<duty); D=0 SHALL give constant 0, and D>P SHALL give constant 1.
REQ-027 Counter arithmetic SHALL be unsigned CNT_W bits and SHALL never exceed period.
REQ-028 led SHALL be registered, reflecting channel state with exactly one cycle of latency.
REQ-029 A written mode SHALL therefore appear on led two cycles after the cfg_we cycle.
REQ-030 Channels SHALL be independent and all SHALL share the single tick.

Reset
REQ-031 With reset high at a clock edge, the next state SHALL be: prescaler 0, tick 0, led all 0, every channel mode OFF, period 0, duty 0, cnt 0, phase 0.
REQ-032 Reset SHALL override cfg_we and stop in the same cycle.
REQ-033 Reset asserted mid-operation SHALL abort all patterns in that same cycle, with no residual state.
REQ-034 After reset deasserts, the first tick SHALL occur PRESCALE cycles later.

Verification (NCH=4, CH_W=3, CNT_W=8, PRESCALE=4)
REQ-035 Release reset -> led=0000, tick=0; tick pulses at cycles 4, 8, 12 after release.
REQ-036 Write ch0 BLINK P=2 -> led[0] is 0 for 3 ticks (12 cycles), 1 for 3 ticks, and repeats; other LEDs stay 0.
REQ-037 Write ch1 PWM P=3 D=1 -> led[1] is high 4 cycles of every 16; then D=0 -> constant 0; then D=5 -> constant 1.
REQ-038 Running ch0 BLINK, hold stop high for 20 cycles -> tick=0 and led frozen; after release, the pattern resumes at the same cnt and phase.
REQ-039 Write ch2 ON in the same cycle as a tick -> led[2]=1 two cycles later; write cfg_ch=5 -> no state change; write ch3 OFF -> led[3]=0 two cycles later.
REQ-040 Pulse reset during active BLINK/PWM on all channels -> led=0000 and tick=0 the next cycle, and all channels are in OFF mode.

Source files
------------

// File: rtl/led_array_ctrl.sv
// led_array_ctrl: multi-channel LED driver with a shared prescaler tick.
// Each channel runs OFF, ON, BLINK or PWM from its own period/duty registers.
module led_array_ctrl #(
  parameter int NCH      = 4,
  parameter int CH_W     = 2,
  parameter int CNT_W    = 8,
  parameter int PRESCALE = 1000
) (
  input  logic             sys_clock,
  input  logic             reset,
  input  logic             stop,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [1:0]       cfg_mode,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_duty,
  output logic [NCH-1:0]   led,
  output logic             tick
);

  localparam int              PS_W    = $clog2(PRESCALE);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PWM   = 2'd3
  } mode_e;

  logic [PS_W-1:0]  presc_q, presc_d;
  logic             tick_q, tick_d;
  mode_e            mode_q   [NCH];
  mode_e            mode_d   [NCH];
  logic [CNT_W-1:0] period_q [NCH];
  logic [CNT_W-1:0] period_d [NCH];
  logic [CNT_W-1:0] duty_q   [NCH];
  logic [CNT_W-1:0] duty_d   [NCH];
  logic [CNT_W-1:0] cnt_q    [NCH];
  logic [CNT_W-1:0] cnt_d    [NCH];
  logic [NCH-1:0]   phase_q, phase_d;
  logic [NCH-1:0]   led_q, led_d;
  logic             advance;

  // A registered tick only moves the channels while the block is not frozen.
  assign advance = tick_q & ~stop;
  assign led     = led_q;
  assign tick    = tick_q;

  // Prescaler wraps at PRESCALE-1 and raises tick for the following cycle; stop freezes it.
  always_comb begin
    presc_d = presc_q;
    tick_d  = 1'b0;
    if (!stop) begin
      tick_d  = (presc_q == PS_LAST);
      presc_d = (presc_q == PS_LAST) ? '0 : presc_q + 1'b1;
    end
  end

  // Per-channel next state: a write wins over a tick, otherwise BLINK/PWM count on each tick.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      mode_d[i]   = mode_q[i];
      period_d[i] = period_q[i];
      duty_d[i]   = duty_q[i];
      cnt_d[i]    = cnt_q[i];
      phase_d[i]  = phase_q[i];
      if (cfg_we && (int'(cfg_ch) == i)) begin
        mode_d[i]   = mode_e'(cfg_mode);
        period_d[i] = cfg_period;
        duty_d[i]   = cfg_duty;
        cnt_d[i]    = '0;
        phase_d[i]  = 1'b0;
      end else if (advance) begin
        case (mode_q[i])
          MODE_BLINK: begin
            if (cnt_q[i] == period_q[i]) begin
              cnt_d[i]   = '0;
              phase_d[i] = ~phase_q[i];
            end else begin
              cnt_d[i] = cnt_q[i] + 1'b1;
            end
          end
          MODE_PWM: cnt_d[i] = (cnt_q[i] >= period_q[i]) ? '0 : cnt_q[i] + 1'b1;
          default: ;
        endcase
      end
    end
  end

  // LED drive is decoded from the current channel state and held while frozen.
  always_comb begin
    led_d = led_q;
    if (!stop) begin
      for (int i = 0; i < NCH; i++) begin
        case (mode_q[i])
          MODE_OFF:   led_d[i] = 1'b0;
          MODE_ON:    led_d[i] = 1'b1;
          MODE_BLINK: led_d[i] = phase_q[i];
          default:    led_d[i] = (cnt_q[i] < duty_q[i]);
        endcase
      end
    end
  end

  // State registers; reset clears everything and overrides writes and stop.
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
      led_q   <= '0;
      phase_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        mode_q[i]   <= MODE_OFF;
        period_q[i] <= '0;
        duty_q[i]   <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
      led_q   <= led_d;
      phase_q <= phase_d;
      for (int i = 0; i < NCH; i++) begin
        mode_q[i]   <= mode_d[i];
        period_q[i] <= period_d[i];
        duty_q[i]   <= duty_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_led_array_ctrl.sv
// tb_led_array_ctrl: directed bench for led_array_ctrl with NCH=4, CH_W=3, CNT_W=8, PRESCALE=4.
// cyc counts rising edges since the last reset edge; outputs are sampled 1ns after each edge.
module tb_led_array_ctrl;

  localparam int NCH      = 4;
  localparam int CH_W     = 3;
  localparam int CNT_W    = 8;
  localparam int PRESCALE = 4;

  localparam logic [1:0] M_OFF   = 2'd0;
  localparam logic [1:0] M_ON    = 2'd1;
  localparam logic [1:0] M_BLINK = 2'd2;
  localparam logic [1:0] M_PWM   = 2'd3;

  logic             sys_clock = 1'b0;
  logic             reset;
  logic             stop;
  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  logic [1:0]       cfg_mode;
  logic [CNT_W-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_duty;
  logic [NCH-1:0]   led;
  logic             tick;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  led_array_ctrl #(
    .NCH(NCH), .CH_W(CH_W), .CNT_W(CNT_W), .PRESCALE(PRESCALE)
  ) dut (
    .sys_clock (sys_clock),
    .reset     (reset),
    .stop      (stop),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_mode  (cfg_mode),
    .cfg_period(cfg_period),
    .cfg_duty  (cfg_duty),
    .led       (led),
    .tick      (tick)
  );

  // 10ns clock period.
  always #5 sys_clock = ~sys_clock;

  task automatic clockStep();
    @(posedge sys_clock);
    #1;
    cyc++;
  endtask

  // One-cycle configuration write; returns just after the edge that samples it.
  task automatic applyStimulus(input logic [CH_W-1:0] ch, input logic [1:0] mode,
                               input logic [CNT_W-1:0] per, input logic [CNT_W-1:0] duty);
    cfg_we     = 1'b1;
    cfg_ch     = ch;
    cfg_mode   = mode;
    cfg_period = per;
    cfg_duty   = duty;
    clockStep();
    cfg_we     = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  // ch0 BLINK P=2 written at edge 13 (during a tick): led[0] rises at 26, 12-cycle halves.
  function automatic logic blinkExp(input int c);
    if (c < 26) return 1'b0;
    return (((c - 26) / 12) % 2) == 0;
  endfunction

  // ch1 PWM P=3 D=1 written at edge 50: short first high 51..53, then 66+16k .. 69+16k.
  function automatic logic pwmExp(input int c);
    if (c <= 53) return 1'b1;
    return (c >= 66) && (((c - 66) % 16) < 4);
  endfunction

  initial begin
    reset = 1'b1; stop = 1'b0; cfg_we = 1'b0; cfg_ch = '0;
    cfg_mode = '0; cfg_period = '0; cfg_duty = '0;
    repeat (3) clockStep();
    reset = 1'b0;
    cyc = 0;

    // Reset state and prescaler cadence.
    checkOutput("rst_led", led, 4'b0000);
    checkOutput("rst_tick", {3'b000, tick}, 4'b0000);
    repeat (12) begin
      clockStep();
      checkOutput("tick_cadence", {3'b000, tick}, {3'b000, (cyc % 4) == 0});
      checkOutput("idle_led", led, 4'b0000);
    end

    // ch0 BLINK P=2, written in the same cycle as a tick.
    applyStimulus(3'd0, M_BLINK, 8'd2, 8'd0);
    repeat (36) begin
      clockStep();
      checkOutput("blink_ch0", led, {3'b000, blinkExp(cyc)});
    end

    // ch1 PWM P=3 D=1, then D=0, then D=5.
    applyStimulus(3'd1, M_PWM, 8'd3, 8'd1);
    repeat (35) begin
      clockStep();
      checkOutput("pwm_d1", led, {2'b00, pwmExp(cyc), blinkExp(cyc)});
    end
    applyStimulus(3'd1, M_PWM, 8'd3, 8'd0);
    repeat (16) begin
      clockStep();
      checkOutput("pwm_d0", led, {2'b00, 1'b0, blinkExp(cyc)});
    end
    applyStimulus(3'd1, M_PWM, 8'd3, 8'd5);
    repeat (16) begin
      clockStep();
      checkOutput("pwm_d5", led, {2'b00, 1'b1, blinkExp(cyc)});
    end

    // Freeze for 20 cycles away from a tick, then resume 20 cycles later in the pattern.
    repeat (2) begin
      clockStep();
      checkOutput("pre_stop", led, {2'b00, 1'b1, blinkExp(cyc)});
    end
    stop = 1'b1;
    repeat (20) begin
      clockStep();
      checkOutput("stop_tick", {3'b000, tick}, 4'b0000);
      checkOutput("stop_led", led, {2'b00, 1'b1, blinkExp(121)});
    end
    stop = 1'b0;
    repeat (28) begin
      clockStep();
      checkOutput("resume_led", led, {2'b00, 1'b1, blinkExp(cyc - 20)});
      checkOutput("resume_tick", {3'b000, tick}, {3'b000, ((cyc - 20) % 4) == 0});
    end

    // ch2 ON written during a tick, ignored write to ch5, ch3 ON then OFF.
    repeat (3) begin
      clockStep();
      checkOutput("pre_on_led", led, {2'b00, 1'b1, blinkExp(cyc - 20)});
    end
    checkOutput("tick_before_on", {3'b000, tick}, 4'b0001);
    applyStimulus(3'd2, M_ON, 8'd0, 8'd0);
    checkOutput("on_latency", led, {2'b00, 1'b1, blinkExp(cyc - 20)});
    clockStep();
    checkOutput("ch2_on", led, {2'b01, 1'b1, blinkExp(cyc - 20)});
    applyStimulus(3'd5, M_OFF, 8'd0, 8'd0);
    checkOutput("bad_ch", led, {2'b01, 1'b1, blinkExp(cyc - 20)});
    repeat (2) begin
      clockStep();
      checkOutput("bad_ch_hold", led, {2'b01, 1'b1, blinkExp(cyc - 20)});
    end
    applyStimulus(3'd3, M_ON, 8'd0, 8'd0);
    checkOutput("ch3_on_lat", led, {2'b01, 1'b1, blinkExp(cyc - 20)});
    clockStep();
    checkOutput("ch3_on", led, {2'b11, 1'b1, blinkExp(cyc - 20)});
    applyStimulus(3'd3, M_OFF, 8'd0, 8'd0);
    checkOutput("ch3_off_lat", led, {2'b11, 1'b1, blinkExp(cyc - 20)});
    clockStep();
    checkOutput("ch3_off", led, {2'b01, 1'b1, blinkExp(cyc - 20)});

    // Mid-operation reset with a competing write and stop; everything returns to OFF.
    applyStimulus(3'd3, M_PWM, 8'd1, 8'd1);
    repeat (3) clockStep();
    reset = 1'b1; stop = 1'b1;
    cfg_we = 1'b1; cfg_ch = 3'd3; cfg_mode = M_ON; cfg_period = '0; cfg_duty = '0;
    clockStep();
    reset = 1'b0; stop = 1'b0; cfg_we = 1'b0;
    cyc = 0;
    checkOutput("mid_rst_led", led, 4'b0000);
    checkOutput("mid_rst_tick", {3'b000, tick}, 4'b0000);
    repeat (12) begin
      clockStep();
      checkOutput("post_rst_led", led, 4'b0000);
      checkOutput("post_rst_tick", {3'b000, tick}, {3'b000, (cyc % 4) == 0});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
